// File: rtl/plic_claim_master_pkg.sv
// Purpose: shared types and helpers for the APB4 PLIC claim/complete initiator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package plic_claim_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    DELIVER = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Width needed to hold IDs 0..sources (0 is the PLIC's "nothing pending").
  function automatic int id_bits(input int sources);
    return $clog2(sources + 1);
  endfunction

endpackage

// File: rtl/apb4_plic_claim_master.sv
// Purpose: APB4 initiator that claims an ID from one PLIC target on irq and later writes it back to complete.
// Latency: irq seen in IDLE at cycle n -> SETUP n+1 -> ACCESS n+2 -> id_valid n+3 (zero wait states).
// Backpressure: PREADY stretches ACCESS; id_valid holds until id_ready; cpl_valid is only taken in IDLE (cpl_ready pulse).
//
// Optional feature: define PLIC_CLAIM_MASTER_TIMEOUT_EN to abandon a transfer after TIMEOUT_CYCLES
// ACCESS cycles with PREADY low (err pulse, back to IDLE). Without it ACCESS waits indefinitely.
//
// Ports:
//   PCLK, PRESETn                      clock / async active-low reset
//   PSEL..PWDATA, PRDATA/PREADY/PSLVERR APB4 initiator port (single target register at CLAIM_ADDR)
//   irq                                PLIC target interrupt level
//   id_valid/id/id_ready               claimed ID handed to the consumer
//   cpl_valid/cpl_id/cpl_ready         completion request from the consumer
//   err                                one-cycle pulse on slave error, bad ID or timeout
module apb4_plic_claim_master
  import plic_claim_master_pkg::*;
#(
  parameter int                    PADDR_SIZE     = 32,
  parameter int                    PDATA_SIZE     = 32,
  parameter int                    SOURCES        = 64,
  parameter logic [PADDR_SIZE-1:0] CLAIM_ADDR     = '0,
  parameter int                    TIMEOUT_CYCLES = 255,
  localparam int                   SOURCES_BITS   = id_bits(SOURCES)
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic                    irq,
  output logic                    id_valid,
  output logic [SOURCES_BITS-1:0] id,
  input  logic                    id_ready,
  input  logic                    cpl_valid,
  input  logic [SOURCES_BITS-1:0] cpl_id,
  output logic                    cpl_ready,
  output logic                    err
);

  state_t state;
  op_t    op;
  logic   holdoff;   // one-cycle claim suppression after a spurious (ID 0) read

  // Only the low ID bits of the claim register are meaningful.
  logic [SOURCES_BITS-1:0] rd_id;
  logic                    rd_too_big;
  logic                    unused_prdata;
  assign rd_id         = PRDATA[SOURCES_BITS-1:0];
  assign rd_too_big    = (int'(rd_id) > SOURCES);
  assign unused_prdata = ^PRDATA;

  logic timed_out;
`ifdef PLIC_CLAIM_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                     wait_cnt <= '0;
    else if (state == SETUP)          wait_cnt <= '0;
    else if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + 1'b1;
  end

  // Fires on the wait cycle that would bring the counter to TIMEOUT_CYCLES.
  assign timed_out = (int'(wait_cnt) == TIMEOUT_CYCLES - 1);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      op        <= OP_READ;
      holdoff   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSTRB     <= '0;
      PWDATA    <= '0;
      id_valid  <= 1'b0;
      id        <= '0;
      cpl_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      err       <= 1'b0;
      cpl_ready <= 1'b0;
      holdoff   <= 1'b0;
      case (state)
        IDLE: begin
          // Completion wins over a new claim.
          if (cpl_valid) begin
            cpl_ready <= 1'b1;
            op        <= OP_WRITE;
            PSEL      <= 1'b1;
            PADDR     <= CLAIM_ADDR;
            PWRITE    <= 1'b1;
            PSTRB     <= '1;
            PWDATA    <= PDATA_SIZE'(cpl_id);
            state     <= SETUP;
          end else if (irq && !holdoff) begin
            op        <= OP_READ;
            PSEL      <= 1'b1;
            PADDR     <= CLAIM_ADDR;
            PWRITE    <= 1'b0;
            PSTRB     <= '0;
            PWDATA    <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY || timed_out) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PSTRB   <= '0;
            PWDATA  <= '0;
            state   <= IDLE;
          end
          if (PREADY) begin
            if (op == OP_WRITE) begin
              err <= PSLVERR;   // completion counts as consumed either way
            end else if (PSLVERR) begin
              err <= 1'b1;
            end else if (rd_id == '0) begin
              holdoff <= 1'b1;  // spurious: PLIC had nothing left to give
            end else if (rd_too_big) begin
              err <= 1'b1;
            end else begin
              id       <= rd_id;
              id_valid <= 1'b1;
              state    <= DELIVER;
            end
          end else if (timed_out) begin
            err <= 1'b1;
          end
        end
        DELIVER: begin
          if (id_ready) begin
            id_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb4_plic_claim_master.md
Name: apb4_plic_claim_master

Overview:
- APB4 initiator that services one PLIC target on behalf of a simple consumer, such as a small sequencer or a CPU-less interrupt handler.
- When irq is high, it reads the target's claim/complete register, hands the returned ID to the consumer, and later writes the ID back to the same register to complete the interrupt.
- Sits between a PLIC target's irq line and the APB4 fabric that reaches the PLIC's APB4 slave port.

Parameters:
- PADDR_SIZE, 32, PADDR width.
- PDATA_SIZE, 32, PRDATA/PWDATA width (≥ SOURCES_BITS).
- SOURCES, 64, number of PLIC sources; SOURCES_BITS = $clog2(SOURCES+1).
- CLAIM_ADDR, 32'h0, byte address of this target's claim/complete register.
- TIMEOUT_CYCLES, 255, PREADY wait limit; used only with the optional feature.

Ports:
- PCLK  in  1  clock, rising edge
- PRESETn  in  1  asynchronous active-low reset
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  PADDR_SIZE  always CLAIM_ADDR while PSEL=1
- PWRITE  out  1  1=complete write, 0=claim read
- PSTRB  out  PDATA_SIZE/8  all ones on writes, zero on reads
- PWDATA  out  PDATA_SIZE  zero-extended completion ID
- PRDATA  in  PDATA_SIZE  claim read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error
- irq  in  1  PLIC target interrupt request (level)
- id_valid  out  1  claimed ID available
- id  out  SOURCES_BITS  claimed ID
- id_ready  in  1  consumer accepts ID
- cpl_valid  in  1  completion request
- cpl_id  in  SOURCES_BITS  ID to complete
- cpl_ready  out  1  completion accepted
- err  out  1  one-cycle pulse on any error

Behaviour:
- Clock and reset: single clock PCLK; PRESETn is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, captured IDs 0. Reset mid-transfer drops PSEL immediately and discards any held ID or completion.
- FSM states: IDLE, SETUP, ACCESS, DELIVER. All APB and consumer outputs are registered.
- IDLE:
  - If cpl_valid=1: cpl_ready pulses for 1 cycle, cpl_id is captured, op=WRITE, go to SETUP.
  - Else if irq=1 and holdoff=0: op=READ, go to SETUP.
  - Completion has priority over a new claim.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PSTRB/PWDATA valid and stable until the transfer ends. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1; hold while PREADY=0. On PREADY=1, drop PSEL/PENABLE the next cycle, with no back-to-back transfers.
  - READ, PSLVERR=0, 0 < PRDATA[SOURCES_BITS-1:0] ≤ SOURCES: latch id, go to DELIVER.
  - READ returning ID 0 (spurious): go to IDLE, set holdoff for 1 cycle (no immediate re-claim).
  - READ returning ID > SOURCES: err pulse, go to IDLE.
  - READ with PSLVERR=1: err pulse, no delivery, go to IDLE.
  - WRITE: go to IDLE; PSLVERR=1 gives an err pulse, and the completion is still considered consumed.
- PRDATA bits above SOURCES_BITS are ignored.
- DELIVER: id_valid=1 and id stable until id_ready=1; then id_valid drops next cycle and the FSM returns to IDLE. cpl_valid is not accepted in DELIVER.
- Minimum claim latency: irq seen in IDLE at cycle n → SETUP n+1 → ACCESS n+2 (PREADY=1) → id_valid at n+3.
- irq falling during SETUP/ACCESS does not abort the transfer; the PLIC returns 0 and the spurious path applies.

Optional Feature:
- Macro: PLIC_CLAIM_MASTER_TIMEOUT_EN.
- Defined: an 8+ bit wait counter clears on SETUP and increments each ACCESS cycle with PREADY=0. On reaching TIMEOUT_CYCLES, the transfer is abandoned: PSEL/PENABLE drop next cycle, err pulses, FSM goes to IDLE, read data discarded.
- Undefined: no counter; ACCESS waits for PREADY indefinitely.

Decomposition:
- Package plic_claim_master_pkg holds:
  - state_t enum (IDLE, SETUP, ACCESS, DELIVER);
  - op_t enum (OP_READ, OP_WRITE);
  - function id_bits(sources) returning $clog2(sources+1).
- No sub-module needed: single FSM module. The timeout counter stays inline under the macro.

Test Plan:
- Claim path: irq=1, PREADY=1, PRDATA=5 → one read at CLAIM_ADDR with PSEL/PENABLE as SETUP then ACCESS; id_valid=1 with id=5 three cycles after irq; held until id_ready.
- Complete path: cpl_valid=1, cpl_id=5 in IDLE → cpl_ready pulse; write with PWRITE=1, PSTRB=4'hF, PWDATA=32'h5; back to IDLE.
- Priority: cpl_valid=1 and irq=1 in the same IDLE cycle → write issued first, claim read follows.
- Wait states and errors:
  - PREADY low for 3 cycles → PSEL, PENABLE, PADDR stable for 4 ACCESS cycles.
  - Read with PSLVERR=1 → err pulse, no id_valid.
  - PRDATA=0 → no id_valid, 1-cycle gap before the next read.
- Out-of-range and reset: PRDATA=65 (SOURCES=64) → err pulse, no delivery. PRESETn low during ACCESS → PSEL=0 asynchronously, all outputs 0.
- Timeout (macro defined, TIMEOUT_CYCLES=4): PREADY held 0 → transfer abandoned after 4 wait cycles, err pulse, FSM in IDLE.
